// File: rtl/bank_rdata_arbiter_if.sv
// Bus bundle between the bank read ports, the downstream read-return path and
// the read-data return arbiter.
//   master : arbiter side (drives select, valid, grant, acks, starvation flags)
//   slave  : bank / downstream side (drives requests, refresh mask, ready)
// Signals
//   req          bank i holds read data on the mux input until src_ack[i]
//   refresh_busy bank i is refreshing; not eligible for a new grant
//   out_ready    downstream accepts the mux output this cycle
//   mux_sel      registered 8:1 mux select
//   out_valid    mux output valid
//   grant_oh     one-hot of mux_sel, zero while out_valid is low
//   src_ack      one-cycle accept pulse back to the granted bank
//   starve       per-bank starvation flag (zero unless wait counters are built)
interface bank_rdata_arbiter_if #(
    parameter int unsigned NUM_SRC = 8,
    parameter int unsigned SEL_W   = 3
);
    logic [NUM_SRC-1:0] req;
    logic [NUM_SRC-1:0] refresh_busy;
    logic               out_ready;
    logic [SEL_W-1:0]   mux_sel;
    logic               out_valid;
    logic [NUM_SRC-1:0] grant_oh;
    logic [NUM_SRC-1:0] src_ack;
    logic [NUM_SRC-1:0] starve;

    modport master (
        input  req,
        input  refresh_busy,
        input  out_ready,
        output mux_sel,
        output out_valid,
        output grant_oh,
        output src_ack,
        output starve
    );

    modport slave (
        output req,
        output refresh_busy,
        output out_ready,
        input  mux_sel,
        input  out_valid,
        input  grant_oh,
        input  src_ack,
        input  starve
    );
endinterface

// File: rtl/bank_rdata_arbiter.sv
// Round-robin scheduler for the shared 8:1 x 64-bit read-data return mux.
// Picks one eligible bank (requesting and not in refresh), drives the
// registered mux select and runs a valid/ready handshake downstream. On every
// accept the granted bank gets a one-cycle src_ack and arbitration restarts
// from the bank after the one just served, excluding that bank for the
// back-to-back pick so its stale request is never granted twice.
// Ports
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    bank_rdata_arbiter_if.master (req, refresh_busy, out_ready in;
//          mux_sel, out_valid, grant_oh, src_ack, starve out)
// Build option
//   ARB_WAIT_CNT_EN : per-bank wait counters; a starving eligible bank wins
//                     ahead of round-robin (lowest index on ties). Without it
//                     the arbiter is pure round-robin and starve is held at 0.
module bank_rdata_arbiter #(
    parameter int unsigned NUM_SRC  = 8,
    parameter int unsigned SEL_W    = 3,
    parameter int unsigned MAX_WAIT = 15,
    parameter int unsigned WAIT_W   = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    bank_rdata_arbiter_if.master bus
);

    // Elaboration-time parameter sanity checks
    if (SEL_W != $clog2(NUM_SRC)) begin : g_bad_sel_w
        $error("SEL_W must equal clog2(NUM_SRC)");
    end
    if (MAX_WAIT > ((1 << WAIT_W) - 1)) begin : g_bad_wait_w
        $error("WAIT_W too narrow for MAX_WAIT");
    end

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    localparam logic [SEL_W-1:0] LAST_SRC = SEL_W'(NUM_SRC - 1);

    state_e             state_q,    state_d;
    logic [SEL_W-1:0]   rr_ptr_q,   rr_ptr_d;
    logic [SEL_W-1:0]   mux_sel_q,  mux_sel_d;
    logic               out_valid_q, out_valid_d;
    logic [NUM_SRC-1:0] grant_oh_q, grant_oh_d;
    logic [NUM_SRC-1:0] src_ack_q,  src_ack_d;

    logic [NUM_SRC-1:0] elig_c;
    logic [NUM_SRC-1:0] starve_pri_c;
    logic [SEL_W-1:0]   ptr_next_c;
    logic               idle_found_c, acc_found_c;
    logic [SEL_W-1:0]   idle_idx_c,   acc_idx_c;

    // Winner select: starving eligible banks first (lowest index), otherwise
    // the first eligible bank scanning ptr, ptr+1, ... modulo NUM_SRC.
    function automatic logic [SEL_W:0] pick(input logic [NUM_SRC-1:0] vec,
                                            input logic [NUM_SRC-1:0] pri,
                                            input logic [SEL_W-1:0]   ptr);
        logic               found;
        logic [SEL_W-1:0]   idx;
        logic [SEL_W-1:0]   pos;
        logic [NUM_SRC-1:0] pri_vec;
        found   = 1'b0;
        idx     = '0;
        pri_vec = vec & pri;
        if (pri_vec != '0) begin
            for (int unsigned i = 0; i < NUM_SRC; i++) begin
                if (!found && pri_vec[SEL_W'(i)]) begin
                    found = 1'b1;
                    idx   = SEL_W'(i);
                end
            end
        end else begin
            for (int unsigned k = 0; k < NUM_SRC; k++) begin
                pos = SEL_W'((32'(ptr) + k) % NUM_SRC);
                if (!found && vec[pos]) begin
                    found = 1'b1;
                    idx   = pos;
                end
            end
        end
        return {found, idx};
    endfunction

`ifdef ARB_WAIT_CNT_EN
    logic [NUM_SRC-1:0][WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [NUM_SRC-1:0]             starve_q,   starve_d;

    // Per-bank wait counters: count unserved request cycles, saturate,
    // clear on ack or when the request goes away.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        starve_d   = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (!bus.req[i] || src_ack_q[i]) begin
                wait_cnt_d[i] = '0;
            end else if (wait_cnt_q[i] != '1) begin
                wait_cnt_d[i] = wait_cnt_q[i] + WAIT_W'(1);
            end
            starve_d[i] = (32'(wait_cnt_q[i]) >= MAX_WAIT);
        end
    end

    assign starve_pri_c = starve_q;
    assign bus.starve   = starve_q;
`else
    assign starve_pri_c = '0;
    assign bus.starve   = '0;
`endif

    assign elig_c     = bus.req & ~bus.refresh_busy;
    assign ptr_next_c = (mux_sel_q == LAST_SRC) ? '0 : mux_sel_q + SEL_W'(1);

    // Fresh pick from IDLE, and the back-to-back pick made on an accept edge
    // using the advanced pointer with the just-served bank masked off.
    assign {idle_found_c, idle_idx_c} = pick(elig_c, starve_pri_c, rr_ptr_q);
    assign {acc_found_c,  acc_idx_c}  = pick(elig_c & ~grant_oh_q, starve_pri_c, ptr_next_c);

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        mux_sel_d   = mux_sel_q;
        out_valid_d = out_valid_q;
        grant_oh_d  = grant_oh_q;
        src_ack_d   = '0;

        case (state_q)
            ST_IDLE: begin
                if (idle_found_c) begin
                    state_d     = ST_GRANT;
                    mux_sel_d   = idle_idx_c;
                    out_valid_d = 1'b1;
                    grant_oh_d  = NUM_SRC'(1) << idle_idx_c;
                end
            end
            ST_GRANT: begin
                // Grant is held (even if the bank enters refresh) until accepted.
                if (out_valid_q && bus.out_ready) begin
                    src_ack_d = grant_oh_q;
                    rr_ptr_d  = ptr_next_c;
                    if (acc_found_c) begin
                        mux_sel_d  = acc_idx_c;
                        grant_oh_d = NUM_SRC'(1) << acc_idx_c;
                    end else begin
                        state_d     = ST_IDLE;
                        out_valid_d = 1'b0;
                        grant_oh_d  = '0;
                    end
                end
            end
            default: begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b0;
                grant_oh_d  = '0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            mux_sel_q   <= '0;
            out_valid_q <= 1'b0;
            grant_oh_q  <= '0;
            src_ack_q   <= '0;
`ifdef ARB_WAIT_CNT_EN
            wait_cnt_q  <= '0;
            starve_q    <= '0;
`endif
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            mux_sel_q   <= mux_sel_d;
            out_valid_q <= out_valid_d;
            grant_oh_q  <= grant_oh_d;
            src_ack_q   <= src_ack_d;
`ifdef ARB_WAIT_CNT_EN
            wait_cnt_q  <= wait_cnt_d;
            starve_q    <= starve_d;
`endif
        end
    end

    assign bus.mux_sel   = mux_sel_q;
    assign bus.out_valid = out_valid_q;
    assign bus.grant_oh  = grant_oh_q;
    assign bus.src_ack   = src_ack_q;

endmodule

// File: tb/tb_bank_rdata_arbiter.sv
// Self-checking bench for bank_rdata_arbiter. Expected src_ack pulses are
// queued when a grant with out_ready is set up and popped when the DUT acks.
module tb_bank_rdata_arbiter;

    localparam int unsigned NUM_SRC = 8;
    localparam int unsigned SEL_W   = 3;

    logic clk;
    logic rst_n;

    int unsigned checks;
    int unsigned errors;
    logic [7:0]  sb_q[$];
    logic [2:0]  exp_sel;
    logic [2:0]  first_sel;
    logic [2:0]  second_sel;

    bank_rdata_arbiter_if #(.NUM_SRC(NUM_SRC), .SEL_W(SEL_W)) bus ();

    bank_rdata_arbiter #(
        .NUM_SRC  (NUM_SRC),
        .SEL_W    (SEL_W),
        .MAX_WAIT (15),
        .WAIT_W   (4)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_valid"}, 32'(bus.out_valid), 32'd0);
        check_eq({tag, "_oh"},    32'(bus.grant_oh),  32'd0);
        check_eq({tag, "_ack"},   32'(bus.src_ack),   32'd0);
    endtask

    task automatic check_grant(input string tag, input logic [2:0] sel);
        check_eq({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
        check_eq({tag, "_sel"},   32'(bus.mux_sel),   32'(sel));
        check_eq({tag, "_oh"},    32'(bus.grant_oh),  32'(8'(1) << sel));
    endtask

    // Scoreboard: every ack pulse must match the oldest queued expectation
    always @(negedge clk) begin
        if (rst_n && bus.src_ack != '0) begin
            if (sb_q.size() == 0) begin
                check_eq("sb_unexpected_ack", 32'(bus.src_ack), 32'd0);
            end else begin
                check_eq("sb_ack", 32'(bus.src_ack), 32'(sb_q.pop_front()));
            end
        end
    end

    // Stimulus protocol: a granted bank must keep req high until acked
    always @(posedge clk) begin
        if (rst_n) begin
            assert (!(bus.out_valid && |(bus.grant_oh & ~bus.req)))
                else $error("protocol: granted req dropped before src_ack");
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        bus.req = 8'hFF;
        bus.refresh_busy = 8'h00;
        bus.out_ready = 1'b1;

        // 1: reset holds everything low despite requests
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_idle_outputs("rst");
            check_eq("rst_sel",    32'(bus.mux_sel), 32'd0);
            check_eq("rst_starve", 32'(bus.starve),  32'd0);
        end
        tick();
        rst_n = 1'b1;

        // All banks refreshing: nothing eligible, stay idle
        bus.refresh_busy = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            tick();
            @(negedge clk);
            check_idle_outputs("allref");
        end
        tick();
        bus.req = 8'h00;
        bus.refresh_busy = 8'h00;

        // 2: two requesters alternate back-to-back, sel 0,2,0,2,...
        tick();
        bus.req = 8'h05;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check_eq("t2_pre_valid", 32'(bus.out_valid), 32'd0);
        for (int k = 0; k < 6; k++) begin
            tick();
            if (k == 5) bus.req = 8'h04;
            @(negedge clk);
            exp_sel = (k % 2 == 0) ? 3'd0 : 3'd2;
            check_grant("t2", exp_sel);
            sb_q.push_back(8'(1) << exp_sel);
        end
        tick();
        bus.req = 8'h00;
        @(negedge clk);
        check_eq("t2_drain_valid", 32'(bus.out_valid), 32'd0);
        tick();
        tick();
        check_eq("t2_sb_empty", 32'(sb_q.size()), 32'd0);

        // 3: low banks refreshing -> 4,5,6,7,4,5 ; bank 5 held through refresh
        bus.req = 8'hFF;
        bus.refresh_busy = 8'h0F;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (k == 5) begin
                bus.out_ready = 1'b0;
                bus.refresh_busy = 8'h2F;
            end
            @(negedge clk);
            exp_sel = 3'((k % 4) + 4);
            check_grant("t3", exp_sel);
            if (k < 5) sb_q.push_back(8'(1) << exp_sel);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            @(negedge clk);
            check_grant("t3_hold", 3'd5);
            check_eq("t3_hold_ack", 32'(bus.src_ack), 32'd0);
        end
        tick();
        bus.req = 8'h20;
        bus.out_ready = 1'b1;
        sb_q.push_back(8'h20);
        tick();
        bus.req = 8'h00;
        bus.refresh_busy = 8'h00;
        @(negedge clk);
        check_eq("t3_drain_valid", 32'(bus.out_valid), 32'd0);
        tick();
        check_eq("t3_sb_empty", 32'(sb_q.size()), 32'd0);

        // 4: backpressure on a single requester, one ack on release
        bus.req = 8'h08;
        bus.out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            @(negedge clk);
            check_grant("t4_bp", 3'd3);
            check_eq("t4_bp_ack", 32'(bus.src_ack), 32'd0);
        end
        tick();
        bus.out_ready = 1'b1;
        sb_q.push_back(8'h08);
        tick();
        bus.req = 8'h00;
        @(negedge clk);
        check_eq("t4_drain_valid", 32'(bus.out_valid), 32'd0);
        tick();
        tick();
        check_eq("t4_sb_empty", 32'(sb_q.size()), 32'd0);

        // 5: reset during a held grant on bank 6, then restart from pointer 0
        bus.req = 8'h40;
        bus.out_ready = 1'b0;
        tick();
        @(negedge clk);
        check_grant("t5_pre", 3'd6);
        tick();
        rst_n = 1'b0;
        @(negedge clk);
        check_idle_outputs("t5_rst");
        check_eq("t5_rst_sel", 32'(bus.mux_sel), 32'd0);
        tick();
        bus.req = 8'h42;
        bus.out_ready = 1'b1;
        rst_n = 1'b1;
        tick();
        @(negedge clk);
        check_grant("t5_first", 3'd1);
        sb_q.push_back(8'h02);
        tick();
        bus.req = 8'h40;
        @(negedge clk);
        check_grant("t5_second", 3'd6);
        sb_q.push_back(8'h40);
        tick();
        bus.req = 8'h00;
        @(negedge clk);
        check_eq("t5_drain_valid", 32'(bus.out_valid), 32'd0);
        tick();
        check_eq("t5_sb_empty", 32'(sb_q.size()), 32'd0);

        // 6: bank 1 waits behind refresh; pointer sits at 7 so bank 0 is next by round-robin
        bus.req = 8'h02;
        bus.refresh_busy = 8'h02;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (k % 5 == 4) begin
                @(negedge clk);
                check_eq("t6_wait_valid", 32'(bus.out_valid), 32'd0);
            end
        end
        @(negedge clk);
`ifdef ARB_WAIT_CNT_EN
        check_eq("t6_starve", 32'(bus.starve), 32'h02);
        first_sel  = 3'd1;
        second_sel = 3'd0;
`else
        check_eq("t6_starve", 32'(bus.starve), 32'h00);
        first_sel  = 3'd0;
        second_sel = 3'd1;
`endif
        tick();
        bus.req = 8'h03;
        bus.refresh_busy = 8'h00;
        tick();
        @(negedge clk);
        check_grant("t6_first", first_sel);
        sb_q.push_back(8'(1) << first_sel);
        tick();
        bus.req = 8'(1) << second_sel;
        @(negedge clk);
        check_grant("t6_second", second_sel);
        sb_q.push_back(8'(1) << second_sel);
        tick();
        bus.req = 8'h00;
        @(negedge clk);
        check_eq("t6_drain_valid", 32'(bus.out_valid), 32'd0);
        tick();
        tick();
        check_eq("final_sb_empty", 32'(sb_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
